// File: rtl/sad_accumulator.sv
// sad_accumulator: windowed sum-of-absolute-differences over the 17-bit
// {borrow, D[15:0]} results of a 16-bit ripple subtractor.
//
// Each window of WINDOW accepted samples produces three results:
// the SAD, the number of samples with borrow set, and the largest
// absolute difference. The results are held behind a valid/ready
// handshake until the consumer takes them.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset (priority over clr)
//   clr         synchronous abort of the current window or held result
//   in_valid    din carries a subtractor result
//   din         {borrow, D[15:0]}
//   in_ready    registered; high in ACCUM only
//   out_valid   registered; high in HOLD only
//   out_ready   consumer takes the held result
//   sad         sum of absolute differences over the window
//   borrow_cnt  number of samples in the window with borrow = 1
//   max_abs     largest absolute difference in the window
module sad_accumulator #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned SUM_W  = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [16:0]                      din,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SUM_W-1:0]                 sad,
  output logic [$clog2(WINDOW+1)-1:0]      borrow_cnt,
  output logic [15:0]                      max_abs
);

  localparam int unsigned CntW  = $clog2(WINDOW);
  localparam int unsigned BcntW = $clog2(WINDOW + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WINDOW - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [CntW-1:0]    cnt_q;
  logic [SUM_W-1:0]   sad_acc_q;
  logic [BcntW-1:0]   bcnt_acc_q;
  logic [15:0]        max_acc_q;
  logic [SUM_W-1:0]   sad_q;
  logic [BcntW-1:0]   bcnt_q;
  logic [15:0]        max_q;

  logic               borrow;
  logic [15:0]        abs_val;
  logic               xfer;
  logic [SUM_W-1:0]   sad_next;
  logic [BcntW-1:0]   bcnt_next;
  logic [15:0]        max_next;

  // Two's-complement negate when borrow is set. {1, 0x0000} wraps to 0,
  // which is the intended handling of that unreachable code.
  always_comb begin
    borrow    = din[16];
    abs_val   = borrow ? (~din[15:0] + 16'd1) : din[15:0];
    xfer      = in_valid && in_ready_q;
    sad_next  = sad_acc_q + SUM_W'(abs_val);
    bcnt_next = bcnt_acc_q + BcntW'(borrow);
    // Strict compare: an equal sample leaves the max untouched.
    max_next  = (abs_val > max_acc_q) ? abs_val : max_acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= StAccum;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      sad_acc_q   <= '0;
      bcnt_acc_q  <= '0;
      max_acc_q   <= '0;
      sad_q       <= '0;
      bcnt_q      <= '0;
      max_q       <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (xfer) begin
            if (cnt_q == LastIdx) begin
              // Results include the final sample; accumulators restart at zero.
              sad_q       <= sad_next;
              bcnt_q      <= bcnt_next;
              max_q       <= max_next;
              cnt_q       <= '0;
              sad_acc_q   <= '0;
              bcnt_acc_q  <= '0;
              max_acc_q   <= '0;
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + CntW'(1);
              sad_acc_q  <= sad_next;
              bcnt_acc_q <= bcnt_next;
              max_acc_q  <= max_next;
            end
          end
        end
        StHold: begin
          // Output registers keep their values on the way back to ACCUM.
          if (out_ready) begin
            state_q     <= StAccum;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StAccum;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign sad        = sad_q;
  assign borrow_cnt = bcnt_q;
  assign max_abs    = max_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Self-checking bench for sad_accumulator (WINDOW=4, SUM_W=18).
// Directed steps from the test plan followed by a randomized run, all
// checked every cycle against a queue-based reference model.
module tb_sad_accumulator;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 18;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic [16:0]   din;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sad;
  logic [2:0]    borrow_cnt;
  logic [15:0]   max_abs;

  int tests;
  int fails;

  // Reference model state
  bit          m_hold;
  int unsigned m_sad;
  int unsigned m_bcnt;
  int unsigned m_max;
  logic [16:0] m_q[$];

  sad_accumulator #(
    .WINDOW (W),
    .SUM_W  (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .din        (din),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sad        (sad),
    .borrow_cnt (borrow_cnt),
    .max_abs    (max_abs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned abs_of(input logic [16:0] d);
    int unsigned mag;
    mag = int'(d[15:0]);
    if (d[16]) return (65536 - mag) % 65536;
    return mag;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model applies the same cycle's inputs using its own pre-edge state.
  task automatic model_update(input bit v, input logic [16:0] d, input bit ordy, input bit c,
                              input bit r);
    int unsigned s;
    int unsigned b;
    int unsigned mx;
    if (r || c) begin
      m_hold = 0;
      m_sad  = 0;
      m_bcnt = 0;
      m_max  = 0;
      m_q.delete();
    end else if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() == W) begin
        s = 0; b = 0; mx = 0;
        foreach (m_q[i]) begin
          s += abs_of(m_q[i]);
          b += int'(m_q[i][16]);
          if (abs_of(m_q[i]) > mx) mx = abs_of(m_q[i]);
        end
        m_sad  = s;
        m_bcnt = b;
        m_max  = mx;
        m_hold = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic step(input bit v, input logic [16:0] d, input bit ordy, input bit c,
                      input bit r);
    in_valid  = v;
    din       = d;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    @(posedge clk);
    model_update(v, d, ordy, c, r);
    #1;
    check("in_ready",   32'(in_ready),   32'(!m_hold));
    check("out_valid",  32'(out_valid),  32'(m_hold));
    check("sad",        32'(sad),        m_sad);
    check("borrow_cnt", 32'(borrow_cnt), m_bcnt);
    check("max_abs",    32'(max_abs),    m_max);
  endtask

  task automatic check_result(input string tag, input int unsigned s, input int unsigned b,
                              input int unsigned mx);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sad"},   32'(sad),       s);
    check({tag, "_bcnt"},  32'(borrow_cnt), b);
    check({tag, "_max"},   32'(max_abs),   mx);
  endtask

  initial begin
    logic [16:0] basic [4];
    logic [16:0] d;
    tests = 0;
    fails = 0;
    basic[0] = {1'b0, 16'h0002};
    basic[1] = {1'b1, 16'hFFFE};
    basic[2] = {1'b0, 16'h0000};
    basic[3] = {1'b1, 16'hFFF6};
    in_valid = 0; din = '0; out_ready = 0; clr = 0; rst = 1;

    // Reset for 2 cycles with in_valid asserted
    step(1, {1'b0, 16'h1234}, 0, 0, 1);
    step(1, {1'b0, 16'h1234}, 0, 0, 1);

    // Basic window, held (out_ready low)
    for (int i = 0; i < 4; i++) step(1, basic[i], 0, 0, 0);
    check_result("basic", 14, 2, 10);
    step(0, '0, 1, 0, 0);

    // Extremes: four samples of 0 - 65535
    for (int i = 0; i < 4; i++) step(1, {1'b1, 16'h0001}, 0, 0, 0);
    check_result("extreme", 32'h3FFFC, 4, 32'hFFFF);

    // Back-pressure: 5 cycles offered while held
    for (int i = 0; i < 5; i++) step(1, {1'b0, 16'h0100}, 0, 0, 0);
    check("bp_hold_sad", 32'(sad), 32'h3FFFC);
    step(1, {1'b0, 16'h0100}, 1, 0, 0);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1, {1'b0, 16'(i + 1)}, 0, 0, 0);
    check_result("bp_next", 10, 0, 4);
    step(0, '0, 1, 0, 0);

    // Abort after two samples, clr alongside the third
    step(1, {1'b0, 16'h0050}, 0, 0, 0);
    step(1, {1'b1, 16'hFF00}, 0, 0, 0);
    step(1, {1'b0, 16'h0070}, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, {1'b0, 16'h0001}, 0, 0, 0);
    check_result("abort", 4, 0, 1);
    // clr while holding drops the result
    step(0, '0, 1, 1, 0);
    check("clr_hold_sad", 32'(sad), 32'd0);

    // Gaps: alternating in_valid, same data as the basic window
    for (int i = 0; i < 4; i++) begin
      step(1, basic[i], 0, 0, 0);
      if (i < 3) step(0, {1'b1, 16'hAAAA}, 0, 0, 0);
    end
    check_result("gaps", 14, 2, 10);
    step(0, '0, 1, 0, 0);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      d = 17'($urandom);
      if (d[16] && d[15:0] == 16'h0000) d[15:0] = 16'h0001;
      step(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 40) == 0), bit'($urandom_range(0, 80) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sad_accumulator.md
# sad_accumulator

Downstream consumer of the 16-bit ripple subtractor's 17-bit result `{borrow, D[15:0]}`. It converts each difference to an absolute value and accumulates over a fixed window of `WINDOW` samples. For each window it reports:
- the sum of absolute differences (SAD),
- the count of samples whose borrow was set,
- the largest absolute difference.

The result is held behind a valid/ready handshake until the consumer takes it.

## Interface
- `WINDOW`, 16: samples per window; legal range 2..1024.
- `SUM_W`, 20: SAD width; must be ≥ 16 + ceil(log2(WINDOW)), so the sum never overflows.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `clr` input 1: synchronous abort of the current window or held result.
- `in_valid` input 1: `din` carries a subtractor result.
- `din` input 17: `{borrow, D[15:0]}` exactly as produced by the subtractor.
- `in_ready` output 1: block accepts `din` this cycle.
- `out_valid` output 1: window result registers are valid.
- `out_ready` input 1: consumer takes the result.
- `sad` output SUM_W: sum of absolute differences over the window.
- `borrow_cnt` output ceil(log2(WINDOW+1)): number of samples with `borrow`=1.
- `max_abs` output 16: maximum absolute difference in the window.

## Operation
- **Absolute value** (combinational):
  - `borrow`=0: abs = `D`.
  - `borrow`=1: abs = (~`D` + 1) truncated to 16 bits.
  - abs range is 0..65535; -65536 is unreachable.
  - `din` = `{1, 0x0000}` is not producible by the subtractor; the block treats it as abs = 0 and does not flag it.
- **State machine**, two states:
  - **ACCUM**:
    - `in_ready`=1, `out_valid`=0.
    - A transfer occurs when `in_valid` & `in_ready`. On each transfer: sad_acc += abs; bcnt_acc += borrow; max_acc = max(max_acc, abs); sample count += 1.
    - The transfer of sample `WINDOW`-1 (0-based) loads the output registers with the values that include that sample, clears the accumulators and count, and moves to HOLD.
  - **HOLD**:
    - `in_ready`=0, `out_valid`=1.
    - Outputs are stable.
    - When `out_ready`=1, moves to ACCUM on the next edge.
- **Accumulators** start each window at zero; a sample with abs equal to the current max leaves `max_acc` unchanged.
- **`clr`** (any state):
  - Accumulators, sample count and output registers are zeroed; state goes to ACCUM.
  - A sample presented in the same cycle is discarded.
  - A held result is dropped.
- **Simultaneous `clr` and `out_ready` in HOLD:** `clr` semantics apply; the result counts as dropped.
- **`rst`** has priority over `clr`. It is legal mid-window and mid-HOLD.
- **Reset values:**
  - state ACCUM;
  - `in_ready`=1, `out_valid`=0;
  - `sad`=0, `borrow_cnt`=0, `max_abs`=0;
  - all accumulators and count 0.

## Timing
- **Per-sample throughput:** 1 sample/cycle in ACCUM; no bubbles between samples.
- **Result latency:** `out_valid` rises the cycle after the edge that accepts the last sample.
- **Cycle budget:** minimum cycles per window = `WINDOW` + 1, with `out_ready` tied high.
- **Held outputs:** `sad`, `borrow_cnt` and `max_abs` change only on the edge that enters HOLD, on `clr`, or on `rst`.
- **Output registers and HOLD→ACCUM:** on the HOLD→ACCUM edge the output registers keep their values, but `out_valid` drops.
- **`in_ready`:** a registered function of state only; it is never combinationally dependent on `in_valid` or `out_ready`.
- **Back-pressure:** while in HOLD, upstream samples are held off. They are neither lost nor accepted.
- **Critical path:** 16-bit negate, then SUM_W-bit add, in one cycle.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles with `in_valid`=1 → `in_ready`=1, `out_valid`=0, all outputs 0, nothing accumulated.
- **WINDOW=4 basic:** `din` = `{0,0x0002}`, `{1,0xFFFE}`, `{0,0x0000}`, `{1,0xFFF6}` on consecutive cycles → next cycle `out_valid`=1, `sad`=14, `borrow_cnt`=2, `max_abs`=10.
- **Extremes, WINDOW=4, SUM_W=18:** four samples of `{1,0x0001}` (0-65535) → `sad`=0x3FFFC, `borrow_cnt`=4, `max_abs`=0xFFFF; no overflow.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1 → outputs stable and `in_ready`=0 throughout. Then raise `out_ready` → next edge `out_valid`=0. The next window's first sample is accepted the cycle after, and its sums exclude the prior window.
- **Abort:** `WINDOW`=4; after 2 samples, assert `clr` alongside a third sample. Then feed 4 samples of `{0,0x0001}` → result `sad`=4, `borrow_cnt`=0, `max_abs`=1.
- **Gaps:** `in_valid` toggling 1,0,1,0… across a window → result identical to the gap-free run. `out_valid` rises exactly one cycle after the 4th accepted sample.
